meas_sequencer: RTL
===================

Name: meas_sequencer

Overview:
- Sequences one cable-fault measurement shot from a decoded host command byte.
- Shot order: fire the 1 MHz or 5 MHz DA test pulse, open the AD capture window (it overlaps the pulse), then open the UART upload window.
- Sits between the UART receive path and the DA/AD/UART-send datapaths. Replaces level-held command decoding with a strobed, abortable, handshaked state machine.

Parameters:
- CMD_1M, 8'hFF, command code that selects the 1 MHz DA pulse shot.
- CMD_5M, 8'hEF, command code that selects the 5 MHz DA pulse shot.
- CMD_ABORT, 8'h00, command code that aborts a shot in progress.
- PULSE_CYC, 500, number of cycles the DA enable is high. Legal range: >=1.
- CAP_CYC, 900, number of cycles the AD enable is high. Must be > PULSE_CYC.
- SEND_CYC, 2250000, maximum number of cycles the UART send enable is high. Must be >=1.
- CNT_W, 22, counter width. Must satisfy 2^CNT_W > max(CAP_CYC, SEND_CYC).

Ports:
- sys_clk, in, 1, system clock; the only clock.
- sys_rst, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, one-cycle strobe; cmd_data is valid in that cycle.
- cmd_data, in, 8, command byte.
- send_done, in, 1, UART sender reports the upload is complete; ends the send window early.
- da1m_en, out, 1, 1 MHz DA pulse enable.
- da5m_en, out, 1, 5 MHz DA pulse enable.
- ad_en, out, 1, AD capture enable.
- send_en, out, 1, UART send enable.
- mode, out, 1, shot type: 0 = 1M, 1 = 5M. Latched when a command is accepted.
- busy, out, 1, high in every state except IDLE.
- meas_done, out, 1, one-cycle pulse when a shot completes normally.
- cmd_err, out, 1, one-cycle pulse when an unrecognised command arrives in IDLE.

Behaviour:
- Reset and interface:
  - One clock; reset is synchronous and active-high.
  - While sys_rst is high at a sys_clk edge: state = IDLE, counter = 0, and every output (da1m_en, da5m_en, ad_en, send_en, mode, busy, meas_done, cmd_err) = 0.
  - Reset mid-shot behaves the same: all outputs are 0 after that edge.
  - All outputs are registered.
- States: IDLE, FIRE, CAPTURE, SEND, DONE.
- IDLE:
  - On cmd_valid with cmd_data == CMD_1M or CMD_5M: latch mode, clear counter, go to FIRE.
  - On cmd_valid with any other value, including CMD_ABORT: cmd_err = 1 for exactly one cycle; stay in IDLE.
- FIRE:
  - The selected DA enable (mode 0 -> da1m_en, mode 1 -> da5m_en) and ad_en are both high.
  - Counter increments every cycle. When counter == PULSE_CYC-1, go to CAPTURE and keep counting.
  - Net effect: the DA enable is high for exactly PULSE_CYC cycles. The unselected DA enable stays 0.
- CAPTURE:
  - Only ad_en is high.
  - When counter == CAP_CYC-1, clear counter and go to SEND.
  - Net effect: ad_en is high for exactly CAP_CYC cycles, contiguous across FIRE and CAPTURE.
- SEND:
  - send_en is high and the counter increments.
  - Leave for DONE when counter == SEND_CYC-1 or when send_done is sampled high, whichever comes first. send_en is low in the next cycle.
  - send_done sampled outside SEND is ignored.
- DONE:
  - meas_done = 1 for one cycle, busy still 1; then go to IDLE.
- Latency:
  - A command accepted at edge k drives enables and busy high from edge k+1.
  - busy falls on the edge after DONE.
  - Total busy time for a full-length shot = CAP_CYC + SEND_CYC + 1 cycles.
- Commands while busy:
  - cmd_valid with CMD_ABORT in FIRE, CAPTURE or SEND: go to IDLE. All enables and busy are 0 after the next edge, counter is cleared, meas_done is not asserted.
  - Any other command while busy (including CMD_1M/CMD_5M) is dropped silently: no cmd_err, no restart.
  - Abort in DONE is ignored; the shot is already complete.
- Simultaneous events in SEND:
  - Abort and send_done in the same cycle: abort wins, no meas_done.
  - send_done on the terminal-count cycle: single transition to DONE, no double pulse.
- Counter behaviour:
  - The counter never wraps during a shot; its terminal compares are exact equality.
  - mode holds its value until the next accepted command.
- Invariants:
  - da1m_en and da5m_en are never high together.
  - send_en is never high together with ad_en.

Test Plan (run with PULSE_CYC=5, CAP_CYC=9, SEND_CYC=20):
- 1M shot: cmd 0xFF at cycle 0 -> da1m_en high cycles 1-5, ad_en high 1-9, send_en high 10-29, meas_done at 30, busy high 1-30, da5m_en stays 0.
- 5M shot with early done: cmd 0xEF, send_done pulsed at cycle 14 -> da5m_en high 1-5, send_en high 10-14, meas_done at 15, mode = 1.
- Abort in CAPTURE: cmd 0xFF, then cmd 0x00 at cycle 7 -> ad_en and busy low from cycle 8, meas_done never asserted; a new 0xFF at cycle 10 starts a clean shot.
- Bad and overlapping commands: 0x55 in IDLE -> cmd_err for one cycle, busy stays 0; 0xEF issued at cycle 3 of a 1M shot -> ignored, mode stays 0, no cmd_err.
- Reset mid-SEND: sys_rst high at cycle 15 -> all outputs 0 at cycle 16; after reset, abort + send_done together in SEND -> IDLE with no meas_done.
- Checker over all runs: the invariants in Behaviour hold every cycle.

Source files
------------

// File: rtl/meas_sequencer.sv
// Cable-fault measurement shot sequencer: DA pulse, overlapping AD capture, then UART upload.
// Strobed host commands start or abort a shot; every output is registered.
module meas_sequencer #(
  parameter logic [7:0]  CMD_1M    = 8'hFF,
  parameter logic [7:0]  CMD_5M    = 8'hEF,
  parameter logic [7:0]  CMD_ABORT = 8'h00,
  parameter int unsigned PULSE_CYC = 500,
  parameter int unsigned CAP_CYC   = 900,
  parameter int unsigned SEND_CYC  = 2250000,
  parameter int unsigned CNT_W     = 22
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       send_done,
  output logic       da1m_en,
  output logic       da5m_en,
  output logic       ad_en,
  output logic       send_en,
  output logic       mode,
  output logic       busy,
  output logic       meas_done,
  output logic       cmd_err
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_CYC - 1);
  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(SEND_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               da1m_q, da1m_d;
  logic               da5m_q, da5m_d;
  logic               ad_q, ad_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               abort_c;
  logic               start_c;

  assign abort_c = cmd_valid && (cmd_data == CMD_ABORT);
  assign start_c = cmd_valid && ((cmd_data == CMD_1M) || (cmd_data == CMD_5M));

  // Next state plus outputs derived from the next state, so the enables line up with the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          mode_d  = (cmd_data == CMD_5M);
          cnt_d   = '0;
          state_d = S_FIRE;
        end else if (cmd_valid) begin
          err_d = 1'b1;
        end
      end
      S_FIRE: begin
        if (abort_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == PULSE_LAST) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (abort_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CAP_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        // Abort takes priority over an upload completion in the same cycle.
        if (abort_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (send_done || (cnt_q == SEND_LAST)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    da1m_d = (state_d == S_FIRE) && !mode_d;
    da5m_d = (state_d == S_FIRE) && mode_d;
    ad_d   = (state_d == S_FIRE) || (state_d == S_CAPTURE);
    send_d = (state_d == S_SEND);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      da1m_q  <= 1'b0;
      da5m_q  <= 1'b0;
      ad_q    <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      da1m_q  <= da1m_d;
      da5m_q  <= da5m_d;
      ad_q    <= ad_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign da1m_en   = da1m_q;
  assign da5m_en   = da5m_q;
  assign ad_en     = ad_q;
  assign send_en   = send_q;
  assign mode      = mode_q;
  assign busy      = busy_q;
  assign meas_done = done_q;
  assign cmd_err   = err_q;

endmodule
